// File: rtl/strobe_delay.sv
// -----------------------------------------------------------------------------
// strobe_delay
//
// Purpose:
//   Delays a one-cycle strobe and its payload by a runtime-programmable number
//   of cycles D (1..MAX_DELAY). Strobes may be issued every cycle and overlap in
//   flight. Order is preserved, and a count of in-flight strobes is maintained.
//   Loading a new D discards every strobe still in flight.
//
// Configuration macro:
//   STROBE_DELAY_HOLD_EN
//     defined     : data_out holds the last emitted payload between pulses.
//     not defined : data_out is 0 whenever strobe_out is 0.
//
// Ports:
//   clk         in           rising-edge clock
//   reset       in           asynchronous active-high reset
//   strobe_in   in           one-cycle qualifier for data_in
//   data_in     in  [WIDTH]  payload, sampled when strobe_in is high
//   delay_load  in           load delay_in (clamped) into the delay register
//   delay_in    in  [DW]     requested delay
//   strobe_out  out          delayed strobe (registered)
//   data_out    out [WIDTH]  delayed payload
//   delay       out [DW]     current delay register D
//   inflight    out [DW]     accepted strobes not yet emitted
//   busy        out          inflight != 0
// -----------------------------------------------------------------------------
module strobe_delay #(
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 2,
    parameter int DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             delay_load,
    input  logic [DW-1:0]    delay_in,
    output logic             strobe_out,
    output logic [WIDTH-1:0] data_out,
    output logic [DW-1:0]    delay,
    output logic [DW-1:0]    inflight,
    output logic             busy
);

    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);
    localparam logic [DW-1:0] ONE_D = DW'(1);

    // Shift line: slot 0 is emitted on the next edge. A strobe accepted under
    // delay D enters slot D-1, so it reaches the output register exactly D
    // edges later. Slots at or above D are always empty, because loading a
    // new D flushes the whole line.
    logic [MAX_DELAY-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]     dat_q [MAX_DELAY];
    logic [WIDTH-1:0]     dat_d [MAX_DELAY];

    logic [DW-1:0]    delay_q, delay_d;
    logic [DW-1:0]    inflight_q, inflight_d;
    logic             strobe_out_q, strobe_out_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic [DW-1:0] clamped;
    logic [DW-1:0] eff_delay;
    logic [DW-1:0] ins_idx;
    logic          emit;

    // Requested delay forced into 1..MAX_DELAY.
    always_comb begin
        if (delay_in == '0) begin
            clamped = ONE_D;
        end else if (delay_in > MAX_D) begin
            clamped = MAX_D;
        end else begin
            clamped = delay_in;
        end
    end

    // A strobe arriving together with a load uses the new delay.
    assign eff_delay = delay_load ? clamped : delay_q;
    assign ins_idx   = eff_delay - ONE_D;

    // Slot 0 leaves on this edge unless a load discards it.
    assign emit = vld_q[0] & ~delay_load;

    always_comb begin
        for (int i = 0; i < MAX_DELAY - 1; i++) begin
            vld_d[i] = vld_q[i+1];
            dat_d[i] = dat_q[i+1];
        end
        vld_d[MAX_DELAY-1] = 1'b0;
        dat_d[MAX_DELAY-1] = '0;

        if (delay_load) begin
            vld_d = '0;
        end

        if (strobe_in) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                if (DW'(i) == ins_idx) begin
                    vld_d[i] = 1'b1;
                    dat_d[i] = data_in;
                end
            end
        end
    end

    always_comb begin
        delay_d = delay_load ? clamped : delay_q;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (delay_load) begin
            // Everything in flight is dropped; only a same-edge strobe survives.
            inflight_d = strobe_in ? ONE_D : '0;
        end else if (strobe_in && !vld_q[0]) begin
            inflight_d = inflight_q + ONE_D;
        end else if (!strobe_in && vld_q[0]) begin
            inflight_d = inflight_q - ONE_D;
        end
    end

    always_comb begin
        strobe_out_d = emit;
`ifdef STROBE_DELAY_HOLD_EN
        data_out_d = emit ? dat_q[0] : data_out_q;
`else
        data_out_d = emit ? dat_q[0] : '0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q        <= '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                dat_q[i] <= '0;
            end
            delay_q      <= DEF_D;
            inflight_q   <= '0;
            strobe_out_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            vld_q        <= vld_d;
            for (int i = 0; i < MAX_DELAY; i++) begin
                dat_q[i] <= dat_d[i];
            end
            delay_q      <= delay_d;
            inflight_q   <= inflight_d;
            strobe_out_q <= strobe_out_d;
            data_out_q   <= data_out_d;
        end
    end

    assign strobe_out = strobe_out_q;
    assign data_out   = data_out_q;
    assign delay      = delay_q;
    assign inflight   = inflight_q;
    assign busy       = (inflight_q != '0);

endmodule

// File: tb/tb_strobe_delay.sv
// -----------------------------------------------------------------------------
// tb_strobe_delay
//
// Directed bench for strobe_delay (WIDTH 8, MAX_DELAY 16, DEFAULT_DELAY 2).
// A table of per-edge vectors covers single strobe, burst, clamping and
// load-with-strobe. Hand-written sequences cover the D = 16 latency, flush on
// load, and asynchronous reset mid-burst. Inputs change 1 ns after each rising
// edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_strobe_delay;

    localparam int WIDTH = 8;
    localparam int MAXD  = 16;
    localparam int DEFD  = 2;
    localparam int DW    = $clog2(MAXD + 1);

    logic             clk;
    logic             reset;
    logic             strobe_in;
    logic [WIDTH-1:0] data_in;
    logic             delay_load;
    logic [DW-1:0]    delay_in;
    logic             strobe_out;
    logic [WIDTH-1:0] data_out;
    logic [DW-1:0]    delay;
    logic [DW-1:0]    inflight;
    logic             busy;

    int n_vec;
    int n_err;

    strobe_delay #(
        .WIDTH        (WIDTH),
        .MAX_DELAY    (MAXD),
        .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .strobe_in  (strobe_in),
        .data_in    (data_in),
        .delay_load (delay_load),
        .delay_in   (delay_in),
        .strobe_out (strobe_out),
        .data_out   (data_out),
        .delay      (delay),
        .inflight   (inflight),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic          stb;
        logic [7:0]    din;
        logic          ld;
        logic [DW-1:0] dly;
        logic          e_stb;
        logic [7:0]    e_data;
        logic [DW-1:0] e_delay;
        logic [DW-1:0] e_inf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] idle_val(input logic [7:0] last);
`ifdef STROBE_DELAY_HOLD_EN
        return last;
`else
        return 8'h00;
`endif
    endfunction

    task automatic add(input logic stb, input logic [7:0] din, input logic ld,
                       input int dly, input logic e_stb, input logic [7:0] e_data,
                       input int e_delay, input int e_inf);
        vec_t v;
        v.stb     = stb;
        v.din     = din;
        v.ld      = ld;
        v.dly     = DW'(dly);
        v.e_stb   = e_stb;
        v.e_data  = e_data;
        v.e_delay = DW'(e_delay);
        v.e_inf   = DW'(e_inf);
        vecs.push_back(v);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic stb, input logic [7:0] din,
                         input logic ld, input int dly);
        strobe_in  = stb;
        data_in    = din;
        delay_load = ld;
        delay_in   = DW'(dly);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_stb, input logic [7:0] e_data,
                           input logic [DW-1:0] e_delay, input logic [DW-1:0] e_inf);
        chk({tag, " strobe_out"}, 32'(strobe_out), 32'(e_stb));
        chk({tag, " data_out"},   32'(data_out),   32'(e_data));
        chk({tag, " delay"},      32'(delay),      32'(e_delay));
        chk({tag, " inflight"},   32'(inflight),   32'(e_inf));
        chk({tag, " busy"},       32'(busy),       32'(e_inf != '0));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        int lat;
        logic [7:0] lat_data;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 0);

        // Table: single strobe at D = 2.
        add(1, 8'hA5, 0, 0,  0, 8'h00, 2, 1);
        add(0, 8'h00, 0, 0,  0, 8'h00, 2, 1);
        add(0, 8'h00, 0, 0,  1, 8'hA5, 2, 0);
        add(0, 8'h00, 0, 0,  0, idle_val(8'hA5), 2, 0);
        // Burst of 8 at D = 5.
        add(0, 8'h00, 1, 5,  0, idle_val(8'hA5), 5, 0);
        for (int j = 0; j < 8; j++) begin
            if (j < 5) add(1, 8'(j + 1), 0, 0, 0, idle_val(8'hA5), 5, j + 1);
            else       add(1, 8'(j + 1), 0, 0, 1, 8'(j - 4), 5, 5);
        end
        for (int j = 8; j < 13; j++) begin
            add(0, 8'h00, 0, 0, 1, 8'(j - 4), 5, 12 - j);
        end
        add(0, 8'h00, 0, 0,  0, idle_val(8'h08), 5, 0);
        // Clamp 0 -> 1, strobe at D = 1.
        add(0, 8'h00, 1, 0,  0, idle_val(8'h08), 1, 0);
        add(1, 8'h11, 0, 0,  0, idle_val(8'h08), 1, 1);
        add(0, 8'h00, 0, 0,  1, 8'h11, 1, 0);
        add(0, 8'h00, 0, 0,  0, idle_val(8'h11), 1, 0);
        // Load with strobe, new D = 1: emits on the following edge.
        add(1, 8'h44, 1, 0,  0, idle_val(8'h11), 1, 1);
        add(0, 8'h00, 0, 0,  1, 8'h44, 1, 0);
        add(0, 8'h00, 0, 0,  0, idle_val(8'h44), 1, 0);
        // Clamp 31 -> 16.
        add(0, 8'h00, 1, 31, 0, idle_val(8'h44), 16, 0);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 8'h00, DW'(DEFD), '0);
        #2;
        reset = 1'b0;

        // Apply the table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stb, vecs[i].din, vecs[i].ld, int'(vecs[i].dly));
            tick();
            chk_all($sformatf("v%0d", i), vecs[i].e_stb, vecs[i].e_data,
                    vecs[i].e_delay, vecs[i].e_inf);
        end

        // Latency at D = 16.
        drive(1'b1, 8'h5A, 1'b0, 0);
        tick();
        chk("d16 accept inflight", 32'(inflight), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 0);
        lat = -1;
        lat_data = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (strobe_out) begin
                lat = k;
                lat_data = data_out;
                break;
            end
        end
        chk("d16 latency", 32'(lat), 32'd16);
        chk("d16 data_out", 32'(lat_data), 32'h5A);
        tick();
        chk("d16 strobe_out after", 32'(strobe_out), 32'd0);
        chk("d16 inflight after", 32'(inflight), 32'd0);

        // Flush: D = 8 with 3 in flight, then load 3 together with strobe 0x3C.
        drive(1'b0, 8'h00, 1'b1, 8);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'(8'h21 + k), 1'b0, 0);
            tick();
        end
        chk("flush pre inflight", 32'(inflight), 32'd3);
        drive(1'b1, 8'h3C, 1'b1, 3);
        tick();
        chk_all("flush load", 1'b0, idle_val(8'h5A), DW'(3), DW'(1));
        drive(1'b0, 8'h00, 1'b0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("flush k%0d strobe_out", k), 32'(strobe_out), 32'(k == 3));
            if (k == 3) chk("flush data_out", 32'(data_out), 32'h3C);
        end
        chk("flush end inflight", 32'(inflight), 32'd0);

        // Async reset mid-burst: D = 4, five strobes, reset while 4 in flight.
        drive(1'b0, 8'h00, 1'b1, 4);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'(8'h61 + k), 1'b0, 0);
            tick();
        end
        chk_all("pre reset", 1'b1, 8'h61, DW'(4), DW'(4));
        drive(1'b0, 8'h00, 1'b0, 0);
        #3;
        reset = 1'b1;
        #1;
        chk_all("async reset", 1'b0, 8'h00, DW'(DEFD), '0);
        #2;
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("post reset k%0d strobe_out", k), 32'(strobe_out), 32'd0);
        end
        chk_all("post reset", 1'b0, 8'h00, DW'(DEFD), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/strobe_delay.md
# strobe_delay

Single-clock, parametrised strobe-and-data delay line. Each `strobe_in` pulse and its `data_in` word reappear on `strobe_out`/`data_out` exactly D cycles later. D is runtime-programmable from 1 to MAX_DELAY. Back-to-back strobes may overlap in flight, and an in-flight count is kept. It sits after the clock-crossing strobe synchronisers and aligns strobed data with pipeline stages of known latency, such as USB bit-stuffing and CRC paths.

## Interface
Parameters:
- `WIDTH`, 8: data bits carried with each strobe.
- `MAX_DELAY`, 16: largest supported delay in cycles. Must be at least 2.
- `DEFAULT_DELAY`, 2: delay register value after reset. Must be in the range 1..MAX_DELAY.
- `DW`, `$clog2(MAX_DELAY+1)`: width of the delay and count fields. Derived; do not override.

Ports:
- `clk` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `strobe_in` in 1: one-cycle qualifier; `data_in` is accepted on cycles where it is high.
- `data_in` in WIDTH: payload, sampled when `strobe_in` is high.
- `delay_load` in 1: loads `delay_in` into the delay register.
- `delay_in` in DW: requested delay.
- `strobe_out` out 1: delayed strobe.
- `data_out` out WIDTH: delayed payload, valid when `strobe_out` is high.
- `delay` out DW: current delay register D.
- `inflight` out DW: number of accepted strobes not yet emitted.
- `busy` out 1: high when `inflight` is not zero.

## Operation
- Reset asserts asynchronously and clears all in-flight state.
  - Output values during reset: `strobe_out` 0, `data_out` 0, `inflight` 0, `busy` 0.
  - The delay register takes DEFAULT_DELAY.
  - The first edge after reset deasserts behaves as a normal cycle.
- Accept: a strobe is accepted when `strobe_in` is 1 at a rising edge. It is emitted exactly D edges later, using the D in force when it was accepted.
- Every cycle may carry a strobe. Up to D strobes can be in flight at once, and order is preserved.
- There is no overflow condition.
- Storage is an implementation choice: a shift register, or a MAX_DELAY-entry circular buffer with read pointer = write pointer − D.
- Delay load: on an edge where `delay_load` is 1, D takes `delay_in` clamped into 1..MAX_DELAY.
  - A request of 0 gives 1. A request above MAX_DELAY gives MAX_DELAY.
  - On the same edge, every in-flight strobe is discarded and `inflight` becomes 0.
  - `strobe_out` is 0 on the cycle after the load edge. The only exception is a strobe accepted under new D = 1, which emits on that cycle.
- Load together with strobe: if `strobe_in` and `delay_load` are both 1 on one edge, the strobe is kept and delayed by the new D. In that case `inflight` becomes 1.
- Counting:
  - `inflight` increments on accept and decrements on emit.
  - An accept and an emit on the same edge leave it unchanged.
  - A discarded strobe is never emitted.
- `busy` is defined as `inflight != 0`.

## Timing
- Latency from `strobe_in` high in cycle t (sampled at edge t) to `strobe_out` high in cycle t+D is exactly D cycles.
- `data_out` in cycle t+D equals the `data_in` sampled at edge t.
- `strobe_out` is registered and is high for exactly one cycle per accepted strobe.
- `delay` and `inflight` are registered. They change one edge after the event that causes the change.
- Changing D has no effect on strobes already accepted, because loading D discards them.
- Reset asserted mid-stream drops all pending strobes immediately and asynchronously.

## Configuration
Macro `STROBE_DELAY_HOLD_EN` controls `data_out` on cycles where `strobe_out` is 0:
- Defined: `data_out` holds the most recently emitted payload. Reset, a delay load, and discards do not disturb this held value, except that reset sets it to 0.
- Not defined: `data_out` is 0 on every cycle where `strobe_out` is 0. Downstream OR-combining of outputs relies on this.
- Timing of `strobe_out` is identical in both builds.

## Test plan
- Reset, then one strobe with D = 2: `data_in` = 0xA5 at edge 10 → `strobe_out` high in cycle 12 only, with `data_out` = 0xA5. `inflight` reads 1 in cycles 10–11 and 0 in cycle 12 after the emit.
- Burst: load D = 5, then 8 consecutive strobes carrying 0x01..0x08 → 8 consecutive output pulses starting 5 cycles after the first, payloads in order. `inflight` peaks at 5 and ends at 0.
- Clamping: load 0 → `delay` = 1. Load 31 with MAX_DELAY = 16 → `delay` = 16. A strobe with D = 16 emerges exactly 16 cycles after acceptance.
- Flush: with D = 8 and 3 strobes in flight, assert `delay_load` with `delay_in` = 3 together with `strobe_in` carrying 0x3C → the 3 old strobes are never emitted, `inflight` = 1, and 0x3C emerges 3 cycles later.
- Async reset mid-burst: assert `reset` between edges while 4 strobes are in flight → `strobe_out` = 0 and `inflight` = 0 immediately. After release, `delay` = DEFAULT_DELAY and no stale pulse appears.
- Idle data value: between pulses, `data_out` = 0 without the macro, or the last payload (e.g. 0x08) with `STROBE_DELAY_HOLD_EN`.
